// File: rtl/fft_bf_sequencer.sv
// rtl/fft_bf_sequencer.sv - radix-2 DIT FFT butterfly sequencer over an external complex sample RAM
//
// Walks an in-place N-point radix-2 decimation-in-time FFT one butterfly at a time:
// reads the operand pair, hands it to an external butterfly unit (bf_go/bf_done),
// and writes the scaled results back to the same two RAM locations.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start / busy / done   run control: start pulse, busy level, done pulse
//   rd_en, rd_addr_a/b    synchronous RAM read (data valid one cycle later)
//   rd_data_a/b           {re[15:8], im[7:0]} signed operands from RAM
//   wr_en, wr_addr_a/b    RAM writeback strobe and addresses (same as read addresses)
//   wr_data_a/b           {re, im} scaled butterfly results
//   tw_addr               twiddle ROM index for the current butterfly
//   bf_go / bf_done       butterfly start pulse / result-valid pulse
//   bf_x1,bf_y1,bf_x2,bf_y2      top (re,im) and bottom (re,im) operands
//   bf_rx1,bf_ry1,bf_rx2,bf_ry2  9-bit butterfly results (top sum, bottom difference)

module fft_bf_sequencer #(
  parameter int LOG2N = 3,
  parameter int SCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [LOG2N-1:0]        rd_addr_a,
  output logic [LOG2N-1:0]        rd_addr_b,
  input  logic [15:0]             rd_data_a,
  input  logic [15:0]             rd_data_b,
  output logic                    wr_en,
  output logic [LOG2N-1:0]        wr_addr_a,
  output logic [LOG2N-1:0]        wr_addr_b,
  output logic [15:0]             wr_data_a,
  output logic [15:0]             wr_data_b,
  output logic [LOG2N-2:0]        tw_addr,
  output logic                    bf_go,
  input  logic                    bf_done,
  output logic signed [7:0]       bf_x1,
  output logic signed [7:0]       bf_y1,
  output logic signed [7:0]       bf_x2,
  output logic signed [7:0]       bf_y2,
  input  logic signed [8:0]       bf_rx1,
  input  logic signed [8:0]       bf_ry1,
  input  logic signed [8:0]       bf_rx2,
  input  logic signed [8:0]       bf_ry2
);

  // Butterfly index spans 0..N/2-1, stage index spans 0..LOG2N-1.
  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [BW-1:0]    B_LAST = '1;
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LAT    = 3'd2,
    GO     = 3'd3,
    WAITBF = 3'd4,
    WR     = 3'd5,
    FIN    = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0]     stage;
  logic [BW-1:0]     bfly;
  logic [15:0]       op_a, op_b;
  logic signed [8:0] res_x1, res_y1, res_x2, res_y2;

  logic [LOG2N-1:0]  half, b_ext, j, top, bot;
  logic [LOG2N-2:0]  tw;
  logic              last_bf;

  // Result narrowing: either a plain arithmetic halving (drop bit 0) or a
  // saturating clamp of the 9-bit result into the signed 8-bit range.
  function automatic logic [7:0] narrow(input logic signed [8:0] v);
    if (SCALE != 0) begin
      return v[8:1];
    end else if (v > 9'sd127) begin
      return 8'h7f;
    end else if (v < -9'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  // Operand addressing for butterfly b of stage s:
  //   group index b>>s is spread out by one extra bit, the low s bits (j) pick the
  //   element inside the group, and the bottom partner sits 'half' above the top.
  //   Bit s of top is always zero, so OR-ing half in is the same as adding it.
  //   The twiddle index strides by N/(2*half) = 1 << (LOG2N-1-s).
  always_comb begin
    half    = ONE << stage;
    b_ext   = {1'b0, bfly};
    j       = b_ext & (half - ONE);
    top     = (((b_ext >> stage) << stage) << 1) | j;
    bot     = top | half;
    tw      = j[LOG2N-2:0] << (S_LAST - stage);
    last_bf = (bfly == B_LAST) && (stage == S_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      state_nxt = LAT;
      LAT:     state_nxt = GO;
      GO:      state_nxt = WAITBF;
      WAITBF:  if (bf_done) state_nxt = WR;
      WR:      state_nxt = last_bf ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      bfly   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_x1 <= '0;
      res_y1 <= '0;
      res_x2 <= '0;
      res_y2 <= '0;
    end else begin
      if (state == IDLE && start) begin
        stage <= '0;
        bfly  <= '0;
      end
      // RAM data arrives during LAT; registering it here keeps the operands
      // stable from GO until the butterfly reports done.
      if (state == LAT) begin
        op_a <= rd_data_a;
        op_b <= rd_data_b;
      end
      if (state == WAITBF && bf_done) begin
        res_x1 <= bf_rx1;
        res_y1 <= bf_ry1;
        res_x2 <= bf_rx2;
        res_y2 <= bf_ry2;
      end
      if (state == WR) begin
        if (bfly == B_LAST) begin
          bfly  <= '0;
          stage <= (stage == S_LAST) ? '0 : stage + SW'(1);
        end else begin
          bfly <= bfly + BW'(1);
        end
      end
    end
  end

  assign bf_x1 = op_a[15:8];
  assign bf_y1 = op_a[7:0];
  assign bf_x2 = op_b[15:8];
  assign bf_y2 = op_b[7:0];

  // Output logic: everything is gated by state so an idle or freshly reset
  // sequencer presents all-zero strobes, addresses and write data.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    bf_go     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    wr_addr_a = '0;
    wr_addr_b = '0;
    wr_data_a = '0;
    wr_data_b = '0;
    tw_addr   = '0;
    case (state)
      IDLE: begin
      end
      RD: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr_a = top;
        rd_addr_b = bot;
      end
      LAT: begin
        busy = 1'b1;
      end
      GO: begin
        busy    = 1'b1;
        bf_go   = 1'b1;
        tw_addr = tw;
      end
      WAITBF: begin
        busy    = 1'b1;
        tw_addr = tw;
      end
      WR: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        wr_addr_a = top;
        wr_addr_b = bot;
        tw_addr   = tw;
        wr_data_a = {narrow(res_x1), narrow(res_y1)};
        wr_data_b = {narrow(res_x2), narrow(res_y2)};
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// tb/tb_fft_bf_sequencer.sv - self-checking bench for fft_bf_sequencer (N=8)

module tb_fft_bf_sequencer;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int NBF   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic              busy, done, rd_en, wr_en, bf_go, bf_done;
  logic [2:0]        rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [15:0]       rd_data_a, rd_data_b, wr_data_a, wr_data_b;
  logic [1:0]        tw_addr;
  logic signed [7:0] bf_x1, bf_y1, bf_x2, bf_y2;
  logic signed [8:0] bf_rx1, bf_ry1, bf_rx2, bf_ry2;

  logic              z_busy, z_done, z_rd_en, z_wr_en, z_bf_go;
  logic [2:0]        z_rd_addr_a, z_rd_addr_b, z_wr_addr_a, z_wr_addr_b;
  logic [15:0]       z_wr_data_a, z_wr_data_b;
  logic [1:0]        z_tw_addr;
  logic signed [7:0] z_bf_x1, z_bf_y1, z_bf_x2, z_bf_y2;

  fft_bf_sequencer #(.LOG2N(LOG2N), .SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .tw_addr(tw_addr),
    .bf_go(bf_go), .bf_done(bf_done),
    .bf_x1(bf_x1), .bf_y1(bf_y1), .bf_x2(bf_x2), .bf_y2(bf_y2),
    .bf_rx1(bf_rx1), .bf_ry1(bf_ry1), .bf_rx2(bf_rx2), .bf_ry2(bf_ry2)
  );

  // Saturating instance runs in lockstep on the same RAM data and butterfly results.
  fft_bf_sequencer #(.LOG2N(LOG2N), .SCALE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(z_busy), .done(z_done),
    .rd_en(z_rd_en), .rd_addr_a(z_rd_addr_a), .rd_addr_b(z_rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(z_wr_en), .wr_addr_a(z_wr_addr_a), .wr_addr_b(z_wr_addr_b),
    .wr_data_a(z_wr_data_a), .wr_data_b(z_wr_data_b), .tw_addr(z_tw_addr),
    .bf_go(z_bf_go), .bf_done(bf_done),
    .bf_x1(z_bf_x1), .bf_y1(z_bf_y1), .bf_x2(z_bf_x2), .bf_y2(z_bf_y2),
    .bf_rx1(bf_rx1), .bf_ry1(bf_ry1), .bf_rx2(bf_rx2), .bf_ry2(bf_ry2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Sample RAM, synchronous read
  logic [15:0] ram [N];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
    end
    if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  // Stub butterfly: rx1=x1+x2, ry1=y1+y2, rx2=x1-x2, ry2=y1-y2+tw after L cycles
  int   lat = 4;
  int   cnt = 0;
  bit   spur_en = 1'b0;
  bit   force_sat = 1'b0;
  logic fire;
  assign fire = (bf_go && lat <= 1) || (!bf_go && cnt == 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_done <= 1'b0;
      cnt     <= 0;
      bf_rx1  <= '0;
      bf_ry1  <= '0;
      bf_rx2  <= '0;
      bf_ry2  <= '0;
    end else begin
      bf_done <= 1'b0;
      if (bf_go) cnt <= (lat <= 1) ? 0 : lat - 1;
      else if (cnt != 0) cnt <= cnt - 1;
      if (fire) begin
        bf_done <= 1'b1;
        if (force_sat) begin
          bf_rx1 <= 9'sd255;
          bf_ry1 <= 9'sd3;
          bf_rx2 <= 9'h100;
          bf_ry2 <= 9'h1fd;
        end else begin
          bf_rx1 <= 9'(int'(bf_x1) + int'(bf_x2));
          bf_ry1 <= 9'(int'(bf_y1) + int'(bf_y2));
          bf_rx2 <= 9'(int'(bf_x1) - int'(bf_x2));
          bf_ry2 <= 9'(int'(bf_y1) - int'(bf_y2) + int'(tw_addr));
        end
      end
      // A spurious done pulse lands in the LAT cycle following each read.
      if (spur_en && rd_en) begin
        bf_done <= 1'b1;
        bf_rx1  <= 9'h0aa;
        bf_ry1  <= 9'h055;
        bf_rx2  <= 9'h133;
        bf_ry2  <= 9'h0cc;
      end
    end
  end

  // Reference model: classic nested group/element FFT loop order plus final RAM image
  int e_top [NBF];
  int e_bot [NBF];
  int e_tw  [NBF];
  int m_re  [N];
  int m_im  [N];

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          mon_en = 1'b0;
  bit          watching = 1'b0;
  int          rd_idx, go_cnt, wr_cnt, done_cnt, done_cyc, base;
  logic [33:0] hold;

  task automatic prep();
    int k = 0;
    for (int i = 0; i < N; i++) begin
      int re = int'($urandom_range(120)) - 60;
      int im = int'($urandom_range(120)) - 60;
      ram[i]  = {8'(re), 8'(im)};
      m_re[i] = re;
      m_im[i] = im;
    end
    for (int s = 0; s < LOG2N; s++) begin
      int half = 1 << s;
      for (int g = 0; g < N; g += 2 * half) begin
        for (int q = 0; q < half; q++) begin
          int t = g + q;
          int b = g + q + half;
          int w = q * (N / (2 * half));
          int a1 = m_re[t] + m_re[b];
          int b1 = m_im[t] + m_im[b];
          int a2 = m_re[t] - m_re[b];
          int b2 = m_im[t] - m_im[b] + w;
          e_top[k] = t;
          e_bot[k] = b;
          e_tw[k]  = w;
          k++;
          m_re[t] = a1 >>> 1;
          m_im[t] = b1 >>> 1;
          m_re[b] = a2 >>> 1;
          m_im[b] = b2 >>> 1;
        end
      end
    end
    rd_idx   = 0;
    go_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1;
    watching = 1'b0;
  endtask

  // Protocol monitor, sampled on the falling edge
  always @(negedge clk) begin
    int cur;
    if (mon_en && rst_n) begin
      if (rd_en) begin
        if (rd_idx < NBF) begin
          check("rd_addr_a", rd_addr_a, e_top[rd_idx]);
          check("rd_addr_b", rd_addr_b, e_bot[rd_idx]);
        end else begin
          check("rd_overrun", rd_idx, NBF - 1);
        end
        rd_idx++;
      end
      cur = (rd_idx == 0) ? 0 : ((rd_idx > NBF) ? NBF - 1 : rd_idx - 1);
      if (bf_go) begin
        go_cnt++;
        hold     = {bf_x1, bf_y1, bf_x2, bf_y2, tw_addr};
        watching = 1'b1;
        check("tw_addr", tw_addr, e_tw[cur]);
      end else if (watching) begin
        check("operand_hold", {bf_x1, bf_y1, bf_x2, bf_y2, tw_addr}, hold);
        if (bf_done) watching = 1'b0;
      end
      if (wr_en) begin
        wr_cnt++;
        check("wr_addr_a", wr_addr_a, e_top[cur]);
        check("wr_addr_b", wr_addr_b, e_bot[cur]);
        check("sat_wr_data_a", z_wr_data_a, {8'(sat8(int'(bf_rx1))), 8'(sat8(int'(bf_ry1)))});
        check("sat_wr_data_b", z_wr_data_b, {8'(sat8(int'(bf_rx2))), 8'(sat8(int'(bf_ry2)))});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - base;
      end
    end
  end

  task automatic run_fft(input int l, input int exp_done, input bit spur, input bit extra, input bit sat);
    bit sat_seen = 1'b0;
    prep();
    lat       = l;
    spur_en   = spur;
    force_sat = sat;
    @(negedge clk);
    start  = 1'b1;
    base   = cyc;
    mon_en = 1'b1;
    for (int t = 1; t <= exp_done + 8; t++) begin
      @(negedge clk);
      start = extra && (t == 5 || t == 50);
      if (sat && wr_en && !sat_seen) begin
        sat_seen = 1'b1;
        check("scale1_wr_a", wr_data_a, 16'h7f01);
        check("scale1_wr_b", wr_data_b, 16'h80fe);
        check("scale0_wr_a", z_wr_data_a, 16'h7f03);
        check("scale0_wr_b", z_wr_data_b, 16'h80fd);
      end
    end
    start = 1'b0;
    if (sat) check("scale_write_seen", sat_seen, 1);
    check("done_cycle", done_cyc, exp_done);
    check("done_count", done_cnt, 1);
    check("go_count", go_cnt, NBF);
    check("rd_count", rd_idx, NBF);
    check("wr_count", wr_cnt, NBF);
    check("busy_after", busy, 0);
    if (!sat) begin
      for (int i = 0; i < N; i++)
        check("ram_result", ram[i], {8'(m_re[i]), 8'(m_im[i])});
    end
    mon_en    = 1'b0;
    spur_en   = 1'b0;
    force_sat = 1'b0;
  endtask

  typedef struct {
    int lat;
    int exp_done;
    bit spur;
    bit extra;
    bit sat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int snap;
    vecs[0] = '{lat: 4,  exp_done: 97,  spur: 1'b0, extra: 1'b0, sat: 1'b0};
    vecs[1] = '{lat: 1,  exp_done: 61,  spur: 1'b0, extra: 1'b0, sat: 1'b0};
    vecs[2] = '{lat: 11, exp_done: 181, spur: 1'b0, extra: 1'b0, sat: 1'b0};
    vecs[3] = '{lat: 1,  exp_done: 61,  spur: 1'b1, extra: 1'b0, sat: 1'b0};
    vecs[4] = '{lat: 11, exp_done: 181, spur: 1'b1, extra: 1'b0, sat: 1'b0};
    vecs[5] = '{lat: 4,  exp_done: 97,  spur: 1'b0, extra: 1'b1, sat: 1'b0};
    vecs[6] = '{lat: 4,  exp_done: 97,  spur: 1'b0, extra: 1'b0, sat: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, rd_en, wr_en, bf_go, rd_addr_a, rd_addr_b,
                         wr_addr_a, wr_addr_b, tw_addr}, 0);
    check("reset_data", {wr_data_a, wr_data_b, bf_x1, bf_y1, bf_x2, bf_y2}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    for (int v = 0; v < 7; v++)
      run_fft(vecs[v].lat, vecs[v].exp_done, vecs[v].spur, vecs[v].extra, vecs[v].sat);

    // Randomized latency and spurious-done runs
    for (int r = 0; r < 4; r++) begin
      int l = int'($urandom_range(9, 1));
      run_fft(l, 1 + NBF * (4 + l), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end

    // Reset in the middle of a run
    prep();
    lat = 4;
    @(negedge clk);
    start  = 1'b1;
    base   = cyc;
    mon_en = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, rd_en, wr_en, bf_go, rd_addr_a, rd_addr_b,
                          wr_addr_a, wr_addr_b, tw_addr}, 0);
    check("midrst_data", {wr_data_a, wr_data_b, bf_x1, bf_y1, bf_x2, bf_y2}, 0);
    snap   = wr_cnt;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check("midrst_no_write", wr_cnt, snap);
    check("midrst_idle", busy, 0);
    run_fft(4, 97, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
